// File: rtl/ser2par_loader.sv
// Serial-to-parallel loader: assembles framed serial bits into a WIDTH-bit word with a load strobe.
// Optional even-parity frame check is enabled by defining PARITY_CHECK_EN.
module ser2par_loader #(
  parameter int WIDTH     = 4,
  parameter int LSB_FIRST = 1
) (
  input  logic             eck,
  input  logic             er,
  input  logic             ein,
  input  logic             evalid,
  input  logic             estart,
  output logic [WIDTH-1:0] sq,
  output logic             sena,
  output logic             sbusy,
  output logic             serr
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef PARITY_CHECK_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PAR, LOAD} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;
`endif

  state_t           state_reg, state_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic [WIDTH-1:0] shift_reg, shift_next;
  logic [WIDTH-1:0] sq_reg, sq_next;
  logic             sena_reg, sena_next;
  logic             sbusy_reg, sbusy_next;
  logic             serr_reg, serr_next;

  // place_mask marks the word bit that receives the cnt_reg-th serial bit;
  // first_mask marks where a frame's first bit lands.
  logic [WIDTH-1:0] place_mask;
  logic [WIDTH-1:0] first_mask;
  logic [WIDTH-1:0] ins_word;
  logic [WIDTH-1:0] start_word;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_mask
      localparam int POS = (LSB_FIRST != 0) ? gi : (WIDTH - 1 - gi);
      assign place_mask[gi] = (cnt_reg == CW'(POS));
      assign first_mask[gi] = (POS == 0);
    end
  endgenerate

  assign ins_word   = (shift_reg & ~place_mask) | (place_mask & {WIDTH{ein}});
  assign start_word = first_mask & {WIDTH{ein}};

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    shift_next = shift_reg;
    sq_next    = sq_reg;
    sena_next  = 1'b0;
    serr_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (evalid && estart) begin
          shift_next = start_word;
          cnt_next   = CW'(1);
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (evalid) begin
          if (estart) begin
            // Abort: partial word is dropped and this bit opens a new frame.
            serr_next  = 1'b1;
            shift_next = start_word;
            cnt_next   = CW'(1);
          end else if (cnt_reg == LAST) begin
            cnt_next = '0;
`ifdef PARITY_CHECK_EN
            shift_next = ins_word;
            state_next = PAR;
`else
            sq_next    = ins_word;
            sena_next  = 1'b1;
            state_next = LOAD;
`endif
          end else begin
            shift_next = ins_word;
            cnt_next   = cnt_reg + CW'(1);
          end
        end
      end
`ifdef PARITY_CHECK_EN
      PAR: begin
        if (evalid) begin
          if (estart) begin
            serr_next  = 1'b1;
            shift_next = start_word;
            cnt_next   = CW'(1);
            state_next = SHIFT;
          end else if ((^{shift_reg, ein}) == 1'b0) begin
            sq_next    = shift_reg;
            sena_next  = 1'b1;
            state_next = LOAD;
          end else begin
            serr_next  = 1'b1;
            state_next = IDLE;
          end
        end
      end
`endif
      LOAD: begin
        state_next = IDLE;
        if (evalid && estart) begin
          shift_next = start_word;
          cnt_next   = CW'(1);
          state_next = SHIFT;
        end else if (evalid) begin
          // Overrun: data arrived without a frame start, bit is dropped.
          serr_next = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
    sbusy_next = (state_next != IDLE);
  end

  always_ff @(posedge eck) begin
    if (!er) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      shift_reg <= '0;
      sq_reg    <= '0;
      sena_reg  <= 1'b0;
      sbusy_reg <= 1'b0;
      serr_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      shift_reg <= shift_next;
      sq_reg    <= sq_next;
      sena_reg  <= sena_next;
      sbusy_reg <= sbusy_next;
      serr_reg  <= serr_next;
    end
  end

  assign sq    = sq_reg;
  assign sena  = sena_reg;
  assign sbusy = sbusy_reg;
  assign serr  = serr_reg;

endmodule

// File: tb/tb_ser2par_loader.sv
// Directed bench for ser2par_loader: LSB-first and MSB-first instances share one serial stream.
// Parity vectors run only when PARITY_CHECK_EN is defined.
module tb_ser2par_loader;

  logic       eck = 1'b0;
  logic       er, ein, evalid, estart;
  logic [3:0] sq, sq_m;
  logic       sena, sbusy, serr;
  logic       sena_m, sbusy_m, serr_m;

  int n_checks = 0;
  int n_fail   = 0;
  int sena_cnt, serr_cnt;
  bit sena_prev, sena_double;

  ser2par_loader #(.WIDTH(4), .LSB_FIRST(1)) dut (
    .eck(eck), .er(er), .ein(ein), .evalid(evalid), .estart(estart),
    .sq(sq), .sena(sena), .sbusy(sbusy), .serr(serr)
  );

  ser2par_loader #(.WIDTH(4), .LSB_FIRST(0)) dut_msb (
    .eck(eck), .er(er), .ein(ein), .evalid(evalid), .estart(estart),
    .sq(sq_m), .sena(sena_m), .sbusy(sbusy_m), .serr(serr_m)
  );

  always #5 eck = ~eck;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, observed, expected);
    end else begin
      $display("ok   %s: %0h", tag, observed);
    end
  endtask

  // One clock: drive inputs, take the edge, then sample outputs 1ns later.
  task automatic cycle(input logic v, input logic s, input logic b);
    evalid = v; estart = s; ein = b;
    @(posedge eck); #1;
    if (sena) begin
      if (sena_prev) sena_double = 1'b1;
      sena_cnt++;
    end
    sena_prev = sena;
    if (serr) serr_cnt++;
  endtask

  task automatic clear_counts();
    sena_cnt = 0; serr_cnt = 0;
  endtask

  // w[k] is the k-th bit sent; returns right after the data edge.
  task automatic send_data(input logic [3:0] w, input int gap);
    for (int k = 0; k < 4; k++) begin
      cycle(1'b1, (k == 0), w[k]);
      if (k < 3) repeat (gap) cycle(1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic send_frame(input logic [3:0] w, input int gap);
    send_data(w, gap);
`ifdef PARITY_CHECK_EN
    repeat (gap) cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, ^w);
`endif
  endtask

  initial begin
    er = 1'b0; ein = 1'b1; evalid = 1'b1; estart = 1'b1;
    sena_prev = 1'b0; sena_double = 1'b0;
    clear_counts();

    // Reset held with active serial input
    cycle(1'b1, 1'b1, 1'b1);
    cycle(1'b1, 1'b1, 1'b1);
    check("rst_sq", sq, 4'h0);
    check("rst_sena", sena, 0);
    check("rst_sbusy", sbusy, 0);
    check("rst_serr", serr, 0);
    er = 1'b1;
    cycle(1'b0, 1'b0, 1'b0);

    // Frame 1,0,1,1 with 2-cycle gaps
    clear_counts();
    send_frame(4'b1101, 2);
    check("gap_sena", sena, 1);
    check("gap_sq", sq, 4'b1101);
    check("gap_sq_msb", sq_m, 4'b1011);
    check("gap_sbusy", sbusy, 1);
    cycle(1'b0, 1'b0, 1'b0);
    check("gap_sena_drop", sena, 0);
    check("gap_idle", sbusy, 0);
    repeat (2) cycle(1'b0, 1'b0, 1'b0);
    check("gap_sena_cnt", sena_cnt, 1);

    // Back-to-back frames, second starts in the LOAD cycle
    clear_counts();
    send_frame(4'b1101, 0);
    check("b2b_sq1", sq, 4'b1101);
    send_frame(4'b0110, 0);
    check("b2b_sq2", sq, 4'b0110);
    check("b2b_sena2", sena, 1);
    cycle(1'b0, 1'b0, 1'b0);
    check("b2b_sena_cnt", sena_cnt, 2);
    check("b2b_serr_cnt", serr_cnt, 0);

    // Abort after 2 bits, restart with 0,0,1,0
    clear_counts();
    cycle(1'b1, 1'b1, 1'b1);
    cycle(1'b1, 1'b0, 1'b1);
    cycle(1'b1, 1'b1, 1'b0);
    check("abort_serr", serr, 1);
    check("abort_busy", sbusy, 1);
    cycle(1'b1, 1'b0, 1'b0);
    check("abort_serr_drop", serr, 0);
    cycle(1'b1, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 1'b0);
`ifdef PARITY_CHECK_EN
    cycle(1'b1, 1'b0, 1'b1);
`endif
    check("abort_sena", sena, 1);
    check("abort_sq", sq, 4'b0100);
    cycle(1'b0, 1'b0, 1'b0);
    check("abort_sena_cnt", sena_cnt, 1);
    check("abort_serr_cnt", serr_cnt, 1);

    // Reset mid-frame, then a clean frame 0,1,0,1
    clear_counts();
    cycle(1'b1, 1'b1, 1'b1);
    cycle(1'b1, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 1'b1);
    er = 1'b0;
    cycle(1'b0, 1'b0, 1'b0);
    er = 1'b1;
    check("midrst_busy", sbusy, 0);
    check("midrst_sq", sq, 4'h0);
    send_frame(4'b1010, 0);
    check("midrst_sq_lsb", sq, 4'b1010);
    check("midrst_sq_msb", sq_m, 4'b0101);
    check("midrst_sena", sena, 1);

    // Overrun: data bit without start in LOAD
    cycle(1'b1, 1'b0, 1'b1);
    check("ovr_serr", serr, 1);
    check("ovr_busy", sbusy, 0);
    check("ovr_sena", sena, 0);
    check("ovr_sq_hold", sq, 4'b1010);

    // Stray bit in IDLE is ignored
    cycle(1'b1, 1'b0, 1'b1);
    check("idle_serr", serr, 0);
    check("idle_busy", sbusy, 0);

`ifdef PARITY_CHECK_EN
    // Good parity then bad parity
    clear_counts();
    send_data(4'b1101, 0);
    check("par_wait_sena", sena, 0);
    check("par_wait_busy", sbusy, 1);
    cycle(1'b1, 1'b0, 1'b1);
    check("par_ok_sena", sena, 1);
    check("par_ok_sq", sq, 4'b1101);
    cycle(1'b0, 1'b0, 1'b0);
    send_data(4'b0110, 0);
    cycle(1'b1, 1'b0, 1'b1);
    check("par_bad_serr", serr, 1);
    check("par_bad_sena", sena, 0);
    check("par_bad_sq", sq, 4'b1101);
    check("par_bad_busy", sbusy, 0);
    cycle(1'b0, 1'b0, 1'b0);
    check("par_sena_cnt", sena_cnt, 1);
`endif

    check("sena_single", sena_double, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
